conv11_seq: RTL and testbench

- Upstream sequencer for the 1x1 convolution calc stage.
- Walks every output channel and every pixel of one single-channel input feature map. It issues synchronous-RAM read addresses for the feature map and for the per-channel weight/bias/scale ROMs.
- Drives the calc stage's enable, aligned to the RAM read data.
- Produces the output-buffer write address and write enable, aligned to the calc stage's registered result. A single start pulse converts one whole layer.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv11_dly.sv | 35 +++
 rtl/conv11_seq.sv | 147 ++++++++++++++
 tb/tb_conv11_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 1x1 convolution sequencer: FSM encoding,
// default layer geometry and the derived pixel/operation counts.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv11_state_t;

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_OUT_CH = 8;
  localparam int PIX_CNT    = DEF_IMG_W * DEF_IMG_H;
  localparam int OP_CNT     = DEF_OUT_CH * PIX_CNT;

  function automatic int pix_count(input int w, input int h);
    return w * h;
  endfunction

  function automatic int op_count(input int w, input int h, input int ch);
    return ch * w * h;
  endfunction

endpackage

// File: rtl/conv11_dly.sv
// Free-running shift register with asynchronous clear. Exposes the full
// final stage plus the top bit of every earlier stage (used as a valid tag).
module conv11_dly #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   i_d,
  output logic [WIDTH-1:0]   o_q,
  output logic [DEPTH-2:0]   o_tag
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  // Shift one stage per clock; never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  always_comb begin
    o_q = r_stage[DEPTH-1];
    for (int i = 0; i < DEPTH - 1; i++) begin
      o_tag[i] = r_stage[i][WIDTH-1];
    end
  end

endmodule

// File: rtl/conv11_seq.sv
// Layer sequencer for the 1x1 convolution calc stage: issues feature/param
// reads (pixel inner loop, channel outer loop) and aligned output writes.
module conv11_seq
  import conv_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int OUT_CH     = DEF_OUT_CH,
  parameter int RD_LAT     = 1,
  parameter int FM_ADDR_W  = 10,
  parameter int CH_ADDR_W  = 3,
  parameter int OUT_ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  output logic                  busy,
  output logic                  done,
  output logic                  fm_rd_en,
  output logic [FM_ADDR_W-1:0]  fm_rd_addr,
  output logic                  prm_rd_en,
  output logic [CH_ADDR_W-1:0]  prm_rd_addr,
  output logic                  conv11_en,
  output logic                  out_wr_en,
  output logic [OUT_ADDR_W-1:0] out_wr_addr
);

  localparam int PIX   = pix_count(IMG_W, IMG_H);
  localparam int DEPTH = RD_LAT + 1;
  localparam int DW    = OUT_ADDR_W + 1;

  localparam logic [FM_ADDR_W-1:0]  P_LAST  = FM_ADDR_W'(PIX - 1);
  localparam logic [CH_ADDR_W-1:0]  OC_LAST = CH_ADDR_W'(OUT_CH - 1);
  localparam logic [FM_ADDR_W-1:0]  P_ONE   = FM_ADDR_W'(1);
  localparam logic [CH_ADDR_W-1:0]  OC_ONE  = CH_ADDR_W'(1);
  localparam logic [OUT_ADDR_W-1:0] OA_ONE  = OUT_ADDR_W'(1);

  conv11_state_t          r_state;
  logic [FM_ADDR_W-1:0]   r_p;
  logic [CH_ADDR_W-1:0]   r_oc;
  logic [OUT_ADDR_W-1:0]  r_ocnt;
  logic [OUT_ADDR_W-1:0]  r_rd_oaddr;
  logic [FM_ADDR_W-1:0]   r_fm_rd_addr;
  logic [CH_ADDR_W-1:0]   r_prm_rd_addr;
  logic                   r_fm_rd_en;
  logic                   r_busy;
  logic                   r_done;
  logic [DW-1:0]          w_last;
  logic [DEPTH-2:0]       w_tag;
  logic                   w_pipe_empty;

  // Only the final (write) stage may still be occupied when DRAIN exits.
  always_comb begin
    w_pipe_empty = ~r_fm_rd_en & ~(|w_tag);
  end

  // Main sequencing FSM with registered strobes and addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_p           <= '0;
      r_oc          <= '0;
      r_ocnt        <= '0;
      r_rd_oaddr    <= '0;
      r_fm_rd_addr  <= '0;
      r_prm_rd_addr <= '0;
      r_fm_rd_en    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_fm_rd_en <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_p     <= '0;
            r_oc    <= '0;
            r_ocnt  <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_busy <= 1'b1;
          if (!pause) begin
            r_fm_rd_en    <= 1'b1;
            r_fm_rd_addr  <= r_p;
            r_prm_rd_addr <= r_oc;
            r_rd_oaddr    <= r_ocnt;
            r_ocnt        <= r_ocnt + OA_ONE;
            if (r_p == P_LAST) begin
              r_p <= '0;
              if (r_oc == OC_LAST) begin
                r_oc    <= '0;
                r_state <= ST_DRAIN;
              end else begin
                r_oc <= r_oc + OC_ONE;
              end
            end else begin
              r_p <= r_p + P_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_busy <= 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  conv11_dly #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({r_fm_rd_en, r_rd_oaddr}),
    .o_q   (w_last),
    .o_tag (w_tag)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign fm_rd_en    = r_fm_rd_en;
  assign prm_rd_en   = r_fm_rd_en;
  assign fm_rd_addr  = r_fm_rd_addr;
  assign prm_rd_addr = r_prm_rd_addr;
  assign conv11_en   = w_tag[RD_LAT-1];
  assign out_wr_en   = w_last[DW-1];
  assign out_wr_addr = w_last[OUT_ADDR_W-1:0];

endmodule

// File: tb/tb_conv11_seq.sv
// Directed bench for conv11_seq: a 2x2x2 RD_LAT=1 instance for the main
// scenarios and a 3x1x3 RD_LAT=3 instance for the long-latency case.
module tb_conv11_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start, pause, start3, pause3;
  int   n_checks = 0;
  int   n_errors = 0;

  logic       busy, done, fm_rd_en, prm_rd_en, conv11_en, out_wr_en;
  logic [1:0] fm_rd_addr;
  logic [0:0] prm_rd_addr;
  logic [2:0] out_wr_addr;

  logic       busy3, done3, fm_rd_en3, prm_rd_en3, conv11_en3, out_wr_en3;
  logic [1:0] fm_rd_addr3;
  logic [1:0] prm_rd_addr3;
  logic [3:0] out_wr_addr3;

  always #5 clk = ~clk;

  conv11_seq #(
    .IMG_W(2), .IMG_H(2), .OUT_CH(2), .RD_LAT(1),
    .FM_ADDR_W(2), .CH_ADDR_W(1), .OUT_ADDR_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .busy(busy), .done(done),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr),
    .prm_rd_en(prm_rd_en), .prm_rd_addr(prm_rd_addr),
    .conv11_en(conv11_en), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr)
  );

  conv11_seq #(
    .IMG_W(3), .IMG_H(1), .OUT_CH(3), .RD_LAT(3),
    .FM_ADDR_W(2), .CH_ADDR_W(2), .OUT_ADDR_W(4)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .pause(pause3),
    .busy(busy3), .done(done3),
    .fm_rd_en(fm_rd_en3), .fm_rd_addr(fm_rd_addr3),
    .prm_rd_en(prm_rd_en3), .prm_rd_addr(prm_rd_addr3),
    .conv11_en(conv11_en3), .out_wr_en(out_wr_en3), .out_wr_addr(out_wr_addr3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read sequence number visible in cycle k (-1 = no read); reads stop for
  // 'gap' cycles starting at cycle 3.
  function automatic int rd_idx(input int k, input int gap);
    if (k < 1) return -1;
    if (k <= 2) return k - 1;
    if (k <= 2 + gap) return -1;
    if (k - 1 - gap <= 7) return k - 1 - gap;
    return -1;
  endfunction

  function automatic int rd3_idx(input int k);
    if (k >= 1 && k <= 9) return k - 1;
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " fm_rd_en"}, fm_rd_en, 0);
    chk({tag, " prm_rd_en"}, prm_rd_en, 0);
    chk({tag, " fm_rd_addr"}, fm_rd_addr, 0);
    chk({tag, " prm_rd_addr"}, prm_rd_addr, 0);
    chk({tag, " conv11_en"}, conv11_en, 0);
    chk({tag, " out_wr_en"}, out_wr_en, 0);
    chk({tag, " out_wr_addr"}, out_wr_addr, 0);
  endtask

  // One layer on the small instance; start is sampled at edge 0.
  task automatic run_scn(input string nm, input int gap, input bit repulse, input int rst_at);
    int ri, ce, wi;
    start = 1'b1;
    for (int k = 0; k <= 12 + gap; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero($sformatf("%s c%0d async-reset", nm, k));
        return;
      end
      ri = rd_idx(k, gap);
      ce = rd_idx(k - 1, gap);
      wi = rd_idx(k - 2, gap);
      chk($sformatf("%s c%0d fm_rd_en", nm, k), fm_rd_en, (ri >= 0));
      chk($sformatf("%s c%0d prm_rd_en", nm, k), prm_rd_en, (ri >= 0));
      if (ri >= 0) begin
        chk($sformatf("%s c%0d fm_rd_addr", nm, k), fm_rd_addr, ri % 4);
        chk($sformatf("%s c%0d prm_rd_addr", nm, k), prm_rd_addr, ri / 4);
      end
      chk($sformatf("%s c%0d conv11_en", nm, k), conv11_en, (ce >= 0));
      chk($sformatf("%s c%0d out_wr_en", nm, k), out_wr_en, (wi >= 0));
      if (wi >= 0) chk($sformatf("%s c%0d out_wr_addr", nm, k), out_wr_addr, wi);
      chk($sformatf("%s c%0d done", nm, k), done, (k == 11 + gap));
      chk($sformatf("%s c%0d busy", nm, k), busy, (k >= 1 && k <= 10 + gap));
      start = repulse && (k == 4 || k == 11 + gap);
      pause = (k + 1 >= 3) && (k + 1 <= 2 + gap);
    end
    start = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    int ri, ce, wi, nwr;
    rst_n  = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    start3 = 1'b0;
    pause3 = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset dut3 busy", busy3, 0);
    chk("reset dut3 out_wr_en", out_wr_en3, 0);
    rst_n = 1'b1;
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    chk("idle pause busy", busy, 0);
    chk("idle pause fm_rd_en", fm_rd_en, 0);

    run_scn("basic", 0, 1'b0, -1);
    run_scn("pause", 2, 1'b0, -1);
    run_scn("repulse", 0, 1'b1, -1);
    run_scn("after_done", 0, 1'b0, -1);
    run_scn("rst_mid", 0, 1'b0, 6);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst c%0d done", k), done, 0);
      chk($sformatf("post_rst c%0d busy", k), busy, 0);
    end
    run_scn("post_rst_run", 0, 1'b0, -1);

    nwr = 0;
    start3 = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      ri = rd3_idx(k);
      ce = rd3_idx(k - 3);
      wi = rd3_idx(k - 4);
      chk($sformatf("lat3 c%0d fm_rd_en", k), fm_rd_en3, (ri >= 0));
      chk($sformatf("lat3 c%0d prm_rd_en", k), prm_rd_en3, (ri >= 0));
      if (ri >= 0) begin
        chk($sformatf("lat3 c%0d fm_rd_addr", k), fm_rd_addr3, ri % 3);
        chk($sformatf("lat3 c%0d prm_rd_addr", k), prm_rd_addr3, ri / 3);
      end
      chk($sformatf("lat3 c%0d conv11_en", k), conv11_en3, (ce >= 0));
      chk($sformatf("lat3 c%0d out_wr_en", k), out_wr_en3, (wi >= 0));
      if (out_wr_en3) nwr++;
      if (wi >= 0) chk($sformatf("lat3 c%0d out_wr_addr", k), out_wr_addr3, wi);
      chk($sformatf("lat3 c%0d done", k), done3, (k == 14));
      chk($sformatf("lat3 c%0d busy", k), busy3, (k >= 1 && k <= 13));
      start3 = 1'b0;
    end
    chk("lat3 write count", nwr, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
